// File: rtl/sdp_ram_pkg.sv
// Shared definitions for the self-initialising simple dual-port RAM:
// FSM state type, read-latency constants and a byte-lane helper.
package sdp_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Read latency in cycles for OUT_REG = 0 and OUT_REG = 1.
  localparam int RD_LAT_OUT_REG0 = 1;
  localparam int RD_LAT_OUT_REG1 = 2;

  function automatic int rd_latency(input int out_reg);
    return (out_reg != 0) ? RD_LAT_OUT_REG1 : RD_LAT_OUT_REG0;
  endfunction

  function automatic int num_bytes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Storage array for sdp_ram_init: one byte-enabled write port and one
// registered read port.  Reading and writing the same address on the
// same edge returns the old word.  The array itself is never reset;
// only the read register is cleared.
module sdp_ram_core
  import sdp_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              waddr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [num_bytes(DATA_W)-1:0]   wbe,
  input  logic                           re,
  input  logic [ADDR_W-1:0]              raddr,
  output logic [DATA_W-1:0]              rdata
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = num_bytes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // Byte-lane write: only lanes with their enable bit set are updated.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read; the register holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sdp_ram_init.sv
// Simple dual-port RAM that fills itself with INIT_VAL after reset or on
// clear_req, one word per cycle, before accepting user reads and writes.
// Optional build macro SDP_RAM_BYPASS_EN: same-address read during write
// returns the new bytes for enabled lanes (write-first, byte merged);
// without it the read returns the old word and no bypass logic exists.
module sdp_ram_init
  import sdp_ram_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 8,
  parameter int                OUT_REG  = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  clear_req,
  output logic                  init_busy
);

  localparam int                NB        = num_bytes(DATA_W);
  localparam int                RD_LAT    = rd_latency(OUT_REG);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] sweep_cnt_reg, sweep_cnt_next;

  logic              core_we;
  logic [ADDR_W-1:0] core_waddr;
  logic [DATA_W-1:0] core_wdata;
  logic [NB-1:0]     core_wbe;
  logic              user_wr;
  logic              rd_fire;
  logic [DATA_W-1:0] core_rdata;
  logic [DATA_W-1:0] merged_data;
  logic              v1_reg;

  // State register and sweep counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_INIT;
      sweep_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_cnt_reg <= sweep_cnt_next;
    end
  end

  // Next state: sweep ascends to the last word, a clear restarts it at 0.
  always_comb begin
    state_next     = state_reg;
    sweep_cnt_next = sweep_cnt_reg;
    case (state_reg)
      ST_INIT: begin
        sweep_cnt_next = sweep_cnt_reg + 1'b1;
        if (sweep_cnt_reg == LAST_ADDR) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_next     = ST_INIT;
          sweep_cnt_next = '0;
        end
      end
      default: begin
        state_next     = ST_INIT;
        sweep_cnt_next = '0;
      end
    endcase
  end

  // Outputs: the sweep owns the write port in INIT, the user in READY.
  always_comb begin
    init_busy  = (state_reg == ST_INIT);
    user_wr    = (state_reg == ST_READY) && wr_en;
    rd_fire    = reset_n && (state_reg == ST_READY) && rd_en;
    core_we    = reset_n && ((state_reg == ST_INIT) || wr_en);
    core_waddr = wr_addr;
    core_wdata = wr_data;
    core_wbe   = wr_be;
    if (state_reg == ST_INIT) begin
      core_waddr = sweep_cnt_reg;
      core_wdata = INIT_VAL;
      core_wbe   = '1;
    end
  end

  sdp_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (core_we),
    .waddr   (core_waddr),
    .wdata   (core_wdata),
    .wbe     (core_wbe),
    .re      (rd_fire),
    .raddr   (rd_addr),
    .rdata   (core_rdata)
  );

`ifdef SDP_RAM_BYPASS_EN
  logic [NB-1:0]     byp_mask_reg;
  logic [DATA_W-1:0] byp_data_reg;

  // Remember which lanes a colliding write overrode, captured with the read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      byp_mask_reg <= '0;
      byp_data_reg <= '0;
    end else if (rd_fire) begin
      byp_mask_reg <= (user_wr && (wr_addr == rd_addr)) ? wr_be : '0;
      byp_data_reg <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_byp_lane
    assign merged_data[8*gi +: 8] = byp_mask_reg[gi] ? byp_data_reg[8*gi +: 8]
                                                     : core_rdata[8*gi +: 8];
  end
`else
  assign merged_data = core_rdata;
`endif

  // First read-pipeline stage: marks the cycle the core read register is fresh.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1_reg <= 1'b0;
    end else begin
      v1_reg <= rd_fire;
    end
  end

  if (RD_LAT == RD_LAT_OUT_REG1) begin : g_out_reg
    logic              v2_reg;
    logic [DATA_W-1:0] rd_data_reg;

    // Optional output register; data only moves on a valid result.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        v2_reg      <= 1'b0;
        rd_data_reg <= '0;
      end else begin
        v2_reg <= v1_reg;
        if (v1_reg) begin
          rd_data_reg <= merged_data;
        end
      end
    end

    assign rd_valid = v2_reg;
    assign rd_data  = rd_data_reg;
  end else begin : g_no_out_reg
    assign rd_valid = v1_reg;
    assign rd_data  = merged_data;
  end

endmodule

// File: tb/tb_sdp_ram_init.sv
// Bench for sdp_ram_init: two instances share stimulus, one with
// OUT_REG=0 / INIT_VAL=A5A5A5A5 and one with OUT_REG=1 / INIT_VAL=0.
// A queue-based reference model predicts every output every cycle.
module tb_sdp_ram_init;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam logic [31:0] IV0 = 32'hA5A5A5A5;
  localparam logic [31:0] IV1 = 32'h00000000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          clear_req;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1;
  logic          busy0, busy1;

  always #5 clk = ~clk;

  sdp_ram_init #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .INIT_VAL(IV0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .clear_req(clear_req),
    .init_busy(busy0));

  sdp_ram_init #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .INIT_VAL(IV1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .clear_req(clear_req),
    .init_busy(busy1));

  typedef struct {
    int          due;
    logic [31:0] d;
  } pend_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  logic [31:0] mem0 [DEPTH];
  logic [31:0] mem1 [DEPTH];
  pend_t       q0[$];
  pend_t       q1[$];
  logic [31:0] last0, last1;
  int          busy_left;
  int          edge_n;
  int          n_cmp;
  int          n_bad;

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: applied once per rising edge with the inputs present there.
  task automatic model_edge();
    logic [31:0] rv0, rv1;
    edge_n++;
    if (!reset_n) begin
      busy_left = DEPTH;
      q0.delete();
      q1.delete();
      last0 = '0;
      last1 = '0;
    end else if (busy_left > 0) begin
      mem0[DEPTH - busy_left] = IV0;
      mem1[DEPTH - busy_left] = IV1;
      busy_left--;
    end else begin
      if (rd_en) begin
        rv0 = mem0[rd_addr];
        rv1 = mem1[rd_addr];
`ifdef SDP_RAM_BYPASS_EN
        if (wr_en && wr_addr == rd_addr) begin
          rv0 = merge(rv0, wr_data, wr_be);
          rv1 = merge(rv1, wr_data, wr_be);
        end
`endif
        q0.push_back('{edge_n, rv0});
        q1.push_back('{edge_n + 1, rv1});
      end
      if (wr_en) begin
        mem0[wr_addr] = merge(mem0[wr_addr], wr_data, wr_be);
        mem1[wr_addr] = merge(mem1[wr_addr], wr_data, wr_be);
      end
      if (clear_req) busy_left = DEPTH;
    end
  endtask

  task automatic compare_all();
    logic ev0, ev1;
    ev0 = (q0.size() > 0) && (q0[0].due == edge_n);
    ev1 = (q1.size() > 0) && (q1[0].due == edge_n);
    if (ev0) begin last0 = q0[0].d; void'(q0.pop_front()); end
    if (ev1) begin last1 = q1[0].d; void'(q1.pop_front()); end
    check("busy0", {31'b0, busy0}, (busy_left > 0) ? 32'd1 : 32'd0);
    check("busy1", {31'b0, busy1}, (busy_left > 0) ? 32'd1 : 32'd0);
    check("rd_valid0", {31'b0, rd_valid0}, {31'b0, ev0});
    check("rd_valid1", {31'b0, rd_valid1}, {31'b0, ev1});
    check("rd_data0", rd_data0, last0);
    check("rd_data1", rd_data1, last1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
  endtask

  // Counts init_busy cycles starting from the edge that began the sweep.
  task automatic count_busy(input bit noise, output int n);
    int guard;
    n = busy1 ? 1 : 0;
    guard = 0;
    while (busy1 && guard < 64) begin
      if (noise) begin
        wr_en = 1'($urandom_range(0, 1)); wr_addr = 4'($urandom_range(0, 15));
        wr_data = $urandom; wr_be = 4'($urandom_range(0, 15));
        rd_en = 1'($urandom_range(0, 1)); rd_addr = 4'($urandom_range(0, 15));
        clear_req = 1'($urandom_range(0, 1));
      end
      step();
      guard++;
      if (busy1) n++;
    end
    idle();
  endtask

  // Streams reads of 0..15 and checks count, contiguity and content.
  task automatic stream_check(input string tag);
    int cnt0, cnt1, first1, last1_idx;
    cnt0 = 0; cnt1 = 0; first1 = -1; last1_idx = -1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      rd_en = (i < DEPTH);
      rd_addr = 4'(i);
      step();
      if (rd_valid0 && rd_data0 == IV0) cnt0++;
      if (rd_valid1) begin
        if (rd_data1 == IV1) cnt1++;
        if (first1 < 0) first1 = i;
        last1_idx = i;
      end
    end
    idle();
    check({tag, "_cnt0"}, 32'(cnt0), 32'd16);
    check({tag, "_cnt1"}, 32'(cnt1), 32'd16);
    check({tag, "_span1"}, 32'(last1_idx - first1 + 1), 32'd16);
    $display("stream %s: dut0 %0d words, dut1 %0d words", tag, cnt0, cnt1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int   n;
    vecs[0] = '{4'd3,  32'h11223344, 4'b0101, 32'hA522A544, 32'h00220044};
    vecs[1] = '{4'd6,  32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[2] = '{4'd9,  32'h12345678, 4'b0000, 32'hA5A5A5A5, 32'h00000000};
    vecs[3] = '{4'd12, 32'h89ABCDEF, 4'b1000, 32'h89A5A5A5, 32'h89000000};
    vecs[4] = '{4'd14, 32'h55667788, 4'b0110, 32'hA56677A5, 32'h00667700};
    n_cmp = 0; n_bad = 0; edge_n = 0; busy_left = DEPTH;
    last0 = '0; last1 = '0;
    idle();

    // Reset and initial sweep length.
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    count_busy(1'b0, n);
    check("init_busy_len", 32'(n), 32'd16);
    $display("reset release: init_busy high %0d cycles", n);

    stream_check("init_readback");

    // Byte-enabled write then read, table driven.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].data; wr_be = vecs[i].be;
      step();
      idle();
      rd_en = 1'b1; rd_addr = vecs[i].addr;
      step();
      check($sformatf("vec%0d_valid0", i), {31'b0, rd_valid0}, 32'd1);
      check($sformatf("vec%0d_data0", i), rd_data0, vecs[i].exp0);
      check($sformatf("vec%0d_early1", i), {31'b0, rd_valid1}, 32'd0);
      idle();
      step();
      check($sformatf("vec%0d_valid1", i), {31'b0, rd_valid1}, 32'd1);
      check($sformatf("vec%0d_data1", i), rd_data1, vecs[i].exp1);
      check($sformatf("vec%0d_drop0", i), {31'b0, rd_valid0}, 32'd0);
      $display("vec%0d addr %0d be %b: dut0 %h dut1 %h", i, vecs[i].addr, vecs[i].be, rd_data0, rd_data1);
    end

    // Same-cycle read and write of one address.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 4'd5;
    step();
`ifdef SDP_RAM_BYPASS_EN
    check("collide_data0", rd_data0, 32'hDEADBEEF);
`else
    check("collide_data0", rd_data0, 32'hA5A5A5A5);
`endif
    idle();
    step();
`ifdef SDP_RAM_BYPASS_EN
    check("collide_data1", rd_data1, 32'hDEADBEEF);
`else
    check("collide_data1", rd_data1, 32'h00000000);
`endif
    $display("collision addr 5: dut0 %h dut1 %h", rd_data0, rd_data1);
    step();

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = 4'($urandom_range(0, 15));
      wr_data = $urandom; wr_be = 4'($urandom_range(0, 15));
      rd_en = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      clear_req = ($urandom_range(0, 49) == 0);
      step();
    end
    idle();
    for (int i = 0; i < 40 && busy1; i++) step();
    $display("random phase done: %0d compared so far", n_cmp);

    // Fill, then clear with a read accepted on the clear cycle.
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = $urandom; wr_be = 4'hF;
      step();
    end
    idle();
    clear_req = 1'b1; rd_en = 1'b1; rd_addr = 4'd2;
    step();
    check("clear_cycle_read_valid0", {31'b0, rd_valid0}, 32'd1);
    idle();
    count_busy(1'b1, n);
    check("clear_busy_len", 32'(n), 32'd16);
    $display("clear: init_busy high %0d cycles", n);
    stream_check("clear_readback");

    // Reset while a read is in flight in the two-stage instance.
    rd_en = 1'b1; rd_addr = 4'd1;
    step();
    idle();
    reset_n = 1'b0;
    step();
    check("inflight_drop1", {31'b0, rd_valid1}, 32'd0);
    reset_n = 1'b1;
    count_busy(1'b0, n);
    check("inflight_busy_len", 32'(n), 32'd16);

    // Reset at sweep count 7.
    clear_req = 1'b1;
    step();
    idle();
    for (int i = 0; i < 7; i++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    count_busy(1'b0, n);
    check("midsweep_busy_len", 32'(n), 32'd16);
    $display("mid-sweep reset: init_busy high %0d cycles", n);
    stream_check("midsweep_readback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
